frame_uart_streamer: RTL

//  Streams one captured camera frame from the frame-buffer RAM read port to the UART Tx, byte by byte.

---
 rtl/frame_uart_streamer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/frame_uart_streamer.sv
// Streams one frame from the frame-buffer RAM read port to the UART Tx, one byte per valid/ready transfer.
// Optional build macro FRAME_HEADER_EN prepends a 3-byte header (A5, 5A, frame count LSB) to each frame.
module frame_uart_streamer #(
    parameter int BYTES_PER_FRAME = 9216,
    parameter int ADDR_W          = 15,
    parameter int DATA_W          = 8,
    parameter int RD_LATENCY      = 1,
    parameter int VS_ACTIVE       = 1,
    parameter int GAP_CYCLES      = 0
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_En,
    input  logic              i_VS,
    output logic              o_Rd_En,
    output logic [ADDR_W-1:0] o_Rd_Addr,
    input  logic [DATA_W-1:0] i_Rd_Data,
    output logic              o_Tx_Valid,
    output logic [DATA_W-1:0] o_Tx_Data,
    input  logic              i_Tx_Ready,
    output logic              o_Busy,
    output logic              o_Frame_Done,
    output logic              o_Overrun,
    output logic [15:0]       o_Frame_Count
);

    localparam int CNT_W = $clog2(BYTES_PER_FRAME + 1);
    localparam int LAT_W = 3;
    localparam int GAP_W = $clog2(GAP_CYCLES + 2);
    localparam logic VS_LVL = (VS_ACTIVE != 0);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_VS = 3'd1;
    localparam logic [2:0] S_FETCH   = 3'd2;
    localparam logic [2:0] S_WAIT_RD = 3'd3;
    localparam logic [2:0] S_SEND    = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
`ifdef FRAME_HEADER_EN
    localparam logic [2:0] S_HDR     = 3'd7;
    logic [1:0]        hdr_idx;
`endif

    logic [2:0]        state;
    logic [CNT_W-1:0]  byte_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DATA_W-1:0] tx_data;
    logic [15:0]       frame_count;
    logic              overrun;
    logic              pend_start;
    logic              vs_meta, vs_sync, vs_prev;
    logic              start_edge;
    logic              last_byte;
    logic              busy;

    // Synchroniser flops reset to the inactive level so reset release alone never looks like a start edge
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            vs_meta <= ~VS_LVL;
            vs_sync <= ~VS_LVL;
            vs_prev <= ~VS_LVL;
        end else begin
            vs_meta <= i_VS;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    assign start_edge = (vs_sync == VS_LVL) && (vs_prev != VS_LVL);
    assign last_byte  = (byte_cnt == CNT_W'(BYTES_PER_FRAME - 1));

    always_comb begin
        busy = (state == S_FETCH) || (state == S_WAIT_RD) || (state == S_SEND) || (state == S_GAP);
`ifdef FRAME_HEADER_EN
        if (state == S_HDR) busy = 1'b1;
`endif
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= S_IDLE;
            byte_cnt    <= '0;
            lat_cnt     <= '0;
            gap_cnt     <= '0;
            tx_data     <= '0;
            frame_count <= '0;
            overrun     <= 1'b0;
            pend_start  <= 1'b0;
`ifdef FRAME_HEADER_EN
            hdr_idx     <= '0;
`endif
        end else begin
            pend_start <= 1'b0;
            if (start_edge && busy) overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (i_En) state <= S_WAIT_VS;
                end
                S_WAIT_VS: begin
                    if (start_edge || pend_start) begin
                        byte_cnt <= '0;
`ifdef FRAME_HEADER_EN
                        hdr_idx  <= '0;
                        tx_data  <= DATA_W'(8'hA5);
                        state    <= S_HDR;
`else
                        state    <= S_FETCH;
`endif
                    end
                end
                S_FETCH: begin
                    lat_cnt <= '0;
                    state   <= S_WAIT_RD;
                end
                S_WAIT_RD: begin
                    if (lat_cnt == LAT_W'(RD_LATENCY - 1)) begin
                        tx_data <= i_Rd_Data;
                        state   <= S_SEND;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                S_SEND: begin
                    if (i_Tx_Ready) begin
                        if (last_byte) begin
                            frame_count <= frame_count + 1'b1;
                            state       <= S_DONE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            if (GAP_CYCLES > 0) begin
                                gap_cnt <= '0;
                                state   <= S_GAP;
                            end else begin
                                state   <= S_FETCH;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt + 1'b1 == GAP_W'(GAP_CYCLES)) state <= S_FETCH;
                    else gap_cnt <= gap_cnt + 1'b1;
                end
                S_DONE: begin
                    // An edge landing in DONE is remembered so WAIT_VS acts on it next cycle
                    if (i_En) begin
                        pend_start <= start_edge;
                        state      <= S_WAIT_VS;
                    end else begin
                        overrun <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
`ifdef FRAME_HEADER_EN
                S_HDR: begin
                    if (i_Tx_Ready) begin
                        if (hdr_idx == 2'd2) begin
                            state <= S_FETCH;
                        end else begin
                            hdr_idx <= hdr_idx + 1'b1;
                            tx_data <= (hdr_idx == 2'd0) ? DATA_W'(8'h5A) : DATA_W'(frame_count[7:0]);
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_Rd_En       = (state == S_FETCH);
    assign o_Rd_Addr     = ADDR_W'(byte_cnt);
    assign o_Tx_Data     = tx_data;
    assign o_Busy        = busy;
    assign o_Frame_Done  = (state == S_DONE);
    assign o_Overrun     = overrun;
    assign o_Frame_Count = frame_count;

`ifdef FRAME_HEADER_EN
    assign o_Tx_Valid = (state == S_SEND) || (state == S_HDR);
`else
    assign o_Tx_Valid = (state == S_SEND);
`endif

endmodule
